// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//   Memory-stage load/store unit. It accepts one access per start pulse and
//   checks funct3 legality and alignment. A legal access is issued on a
//   word-wide req/ack memory port, and the request is held until mem_ack or a
//   timeout. The unit returns extended load data together with a one-cycle
//   done pulse and fault flags.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   start, is_store       one-cycle access request, 1 = store / 0 = load
//   funct3, addr          RV32I width code, byte address
//   store_data            rs2 value for stores
//   busy, done            access in progress, one-cycle completion pulse
//   load_data             extended load result (holds between loads)
//   misaligned, bus_err   fault flags, valid only while done is high
//   mem_req, mem_we       memory request / write enable
//   mem_addr, mem_wstrb   word-aligned address, byte strobes
//   mem_wdata             lane-replicated store data
//   mem_rdata, mem_ack    read word and one-cycle acknowledge
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_data,
    output logic        misaligned,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_store_q, is_store_d;
    logic [2:0]         funct3_q, funct3_d;
    logic [1:0]         off_q, off_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               mis_q, mis_d;
    logic               berr_q, berr_d;
    logic               mem_req_q, mem_req_d;
    logic               mem_we_q, mem_we_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic [3:0]         mem_wstrb_q, mem_wstrb_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;
    logic [31:0]        load_data_q, load_data_d;

    logic               accept;
    logic               illegal;
    logic               unaligned;

    function automatic logic [31:0] extract_load(input logic [2:0]  f3,
                                                 input logic [1:0]  off,
                                                 input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = off[1] ? rdata[31:16] : rdata[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'b0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'b0, h};
            default: return rdata;
        endcase
    endfunction

    function automatic logic [3:0] store_strobe(input logic [2:0] f3,
                                                input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0]  f3,
                                                input logic [31:0] sd);
        case (f3[1:0])
            2'b00:   return {4{sd[7:0]}};
            2'b01:   return {2{sd[15:0]}};
            default: return sd;
        endcase
    endfunction

    // A start landing on the RESP->IDLE edge is accepted so back-to-back
    // accesses lose no cycle; a start during ACCESS is dropped.
    assign accept = start && (state_q != ACCESS);

    always_comb begin
        illegal = 1'b0;
        if (is_store) begin
            illegal = funct3[2] || (funct3[1:0] == 2'b11);
        end else begin
            illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        end
        unaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                    ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_store_d  = is_store_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        done_d      = 1'b0;
        mis_d       = 1'b0;
        berr_d      = 1'b0;
        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wstrb_d = mem_wstrb_q;
        mem_wdata_d = mem_wdata_q;
        load_data_d = load_data_q;

        case (state_q)
            ACCESS: begin
                // An ack in the last permitted cycle wins over the timeout.
                if (mem_ack) begin
                    state_d = RESP;
                    done_d  = 1'b1;
                    if (!is_store_q) begin
                        load_data_d = extract_load(funct3_q, off_q, mem_rdata);
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = RESP;
                    done_d  = 1'b1;
                    berr_d  = 1'b1;
                end else begin
                    cnt_d     = cnt_q + CNT_W'(1);
                    mem_req_d = 1'b1;
                    mem_we_d  = mem_we_q;
                end
            end
            RESP:    state_d = IDLE;
            default: ;
        endcase

        if (accept) begin
            is_store_d = is_store;
            funct3_d   = funct3;
            off_d      = addr[1:0];
            if (illegal) begin
                state_d = RESP;
                done_d  = 1'b1;
                berr_d  = 1'b1;
            end else if (unaligned) begin
                state_d = RESP;
                done_d  = 1'b1;
                mis_d   = 1'b1;
            end else begin
                state_d     = ACCESS;
                cnt_d       = '0;
                mem_req_d   = 1'b1;
                mem_we_d    = is_store;
                mem_addr_d  = {addr[31:2], 2'b00};
                mem_wstrb_d = is_store ? store_strobe(funct3, addr[1:0]) : 4'b0000;
                mem_wdata_d = is_store ? store_lanes(funct3, store_data) : 32'b0;
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            is_store_q  <= 1'b0;
            funct3_q    <= 3'b0;
            off_q       <= 2'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mis_q       <= 1'b0;
            berr_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'b0;
            mem_wstrb_q <= 4'b0;
            mem_wdata_q <= 32'b0;
            load_data_q <= 32'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_store_q  <= is_store_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            mis_q       <= mis_d;
            berr_q      <= berr_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wstrb_q <= mem_wstrb_d;
            mem_wdata_q <= mem_wdata_d;
            load_data_q <= load_data_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign misaligned = mis_q;
    assign bus_err    = berr_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wstrb  = mem_wstrb_q;
    assign mem_wdata  = mem_wdata_q;
    assign load_data  = load_data_q;

endmodule
